// File: rtl/ber_monitor_pkg.sv
// Shared definitions for the BER monitor: FSM state encoding, cumulative counter width
// and a constant clog2 helper used to size pointers and level outputs.
package ber_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } ber_state_e;

    localparam int TOTAL_W = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ber_monitor_if.sv
// Source and decoded bit streams feeding the BER monitor.
interface ber_monitor_if;

    logic src_bit;
    logic src_valid;
    logic dec_bit;
    logic dec_valid;

    modport master (output src_bit, src_valid, dec_bit, dec_valid);
    modport slave  (input  src_bit, src_valid, dec_bit, dec_valid);

endinterface

// File: rtl/ber_monitor_sync_fifo_bit.sv
// 1-bit-wide synchronous FIFO that aligns source bits with the delayed decoder output.
// Read data is the oldest entry, valid combinationally whenever the FIFO is not empty.
module sync_fifo_bit
    import ber_monitor_pkg::*;
#(
    parameter int  DEPTH = 64,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk_sig,
    input  logic          reset_sig,
    input  logic          clear,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          dout,
    output logic          full,
    output logic          empty,
    output logic          push_ok,
    output logic          pop_ok,
    output logic [AW:0]   level
);

    logic [DEPTH-1:0] mem_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    assign full    = (count_r == LW'(DEPTH));
    assign empty   = (count_r == {LW{1'b0}});
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_r[rd_ptr_r];
    assign level   = count_r;

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk_sig) begin
        if (!reset_sig || clear) begin
            mem_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_ok) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: pairs buffered source bits with decoded bits, counts mismatches
// per fixed window and keeps a saturating cumulative error total.
module ber_monitor
    import ber_monitor_pkg::*;
#(
    parameter int  FIFO_DEPTH = 64,
    parameter int  WINDOW     = 1024,
    parameter int  CNT_W      = 16,
    localparam int LVL_W      = clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_sig,
    input  logic               reset_sig,
    input  logic               clear,
    ber_monitor_if.slave       bus,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   bit_count,
    output logic               window_done,
    output logic [TOTAL_W-1:0] total_err,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [1:0]         state,
    output logic               fault
);

    localparam logic [CNT_W-1:0]   WINDOW_C  = CNT_W'(WINDOW);
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

    ber_state_e         state_r;
    ber_state_e         state_next_s;
    logic               fault_r;
    logic               pop_req_s;
    logic               fifo_dout_s;
    logic               full_s;
    logic               empty_s;
    logic               push_ok_s;
    logic               pop_ok_s;
    logic               overflow_s;
    logic               underflow_s;
    logic               cmp_v_r;
    logic               mis_r;
    logic [CNT_W-1:0]   bit_count_r;
    logic [CNT_W-1:0]   run_err_r;
    logic [CNT_W-1:0]   err_count_r;
    logic [CNT_W-1:0]   bit_next_s;
    logic [CNT_W-1:0]   err_next_s;
    logic               window_done_r;
    logic [TOTAL_W-1:0] total_err_r;
    logic [LVL_W-1:0]   level_s;

    // Once faulted the decoder stream is no longer consumed; pushes still fill the FIFO.
    assign pop_req_s   = bus.dec_valid && (state_r != ST_FAULT);
    assign overflow_s  = bus.src_valid && full_s && !push_ok_s;
    assign underflow_s = bus.dec_valid && empty_s;
    assign bit_next_s  = bit_count_r + CNT_W'(1);
    assign err_next_s  = run_err_r + {{(CNT_W-1){1'b0}}, mis_r};

    sync_fifo_bit #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .clear     (clear),
        .push      (bus.src_valid),
        .din       (bus.src_bit),
        .pop       (pop_req_s),
        .dout      (fifo_dout_s),
        .full      (full_s),
        .empty     (empty_s),
        .push_ok   (push_ok_s),
        .pop_ok    (pop_ok_s),
        .level     (level_s)
    );

    // Next-state logic; an empty-FIFO decode in IDLE is simply ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (overflow_s) begin
                    state_next_s = ST_FAULT;
                end else if (pop_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (overflow_s || underflow_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FAULT: state_next_s = ST_FAULT;
            default:  state_next_s = ST_FAULT;
        endcase
    end

    // State register and sticky fault flag.
    always_ff @(posedge clk_sig) begin
        if (!reset_sig || clear) begin
            state_r <= ST_IDLE;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            fault_r <= fault_r || (state_next_s == ST_FAULT);
        end
    end

    // Compare stage: register the mismatch of each accepted pop.
    always_ff @(posedge clk_sig) begin
        if (!reset_sig || clear) begin
            cmp_v_r <= 1'b0;
            mis_r   <= 1'b0;
        end else begin
            cmp_v_r <= pop_ok_s;
            mis_r   <= pop_ok_s && (fifo_dout_s ^ bus.dec_bit);
        end
    end

    // Counter stage: window accounting and saturating cumulative total.
    always_ff @(posedge clk_sig) begin
        if (!reset_sig || clear) begin
            bit_count_r   <= {CNT_W{1'b0}};
            run_err_r     <= {CNT_W{1'b0}};
            err_count_r   <= {CNT_W{1'b0}};
            window_done_r <= 1'b0;
            total_err_r   <= {TOTAL_W{1'b0}};
        end else if (cmp_v_r && (state_r != ST_FAULT)) begin
            if (bit_next_s == WINDOW_C) begin
                err_count_r   <= err_next_s;
                bit_count_r   <= {CNT_W{1'b0}};
                run_err_r     <= {CNT_W{1'b0}};
                window_done_r <= 1'b1;
            end else begin
                bit_count_r   <= bit_next_s;
                run_err_r     <= err_next_s;
                window_done_r <= 1'b0;
            end
            if (mis_r && (total_err_r != TOTAL_MAX)) begin
                total_err_r <= total_err_r + TOTAL_W'(1);
            end else begin
                total_err_r <= total_err_r;
            end
        end else begin
            window_done_r <= 1'b0;
        end
    end

    assign err_count   = err_count_r;
    assign bit_count   = bit_count_r;
    assign window_done = window_done_r;
    assign total_err   = total_err_r;
    assign fifo_level  = level_s;
    assign state       = state_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_ber_monitor.sv
// Scoreboard bench for ber_monitor: three instances cover the default, short-window
// and shallow-FIFO configurations.
module tb_ber_monitor;
    import ber_monitor_pkg::*;

    logic clk_sig = 1'b0;
    logic reset_sig;
    logic clear;
    always #5 clk_sig = ~clk_sig;

    ber_monitor_if if_def ();
    ber_monitor_if if_win ();
    ber_monitor_if if_sml ();

    logic [15:0] d_err, d_bit, w_err, w_bit, s_err, s_bit;
    logic        d_wd, w_wd, s_wd, d_flt, w_flt, s_flt;
    logic [31:0] d_tot, w_tot, s_tot;
    logic [6:0]  d_lvl, w_lvl;
    logic [2:0]  s_lvl;
    logic [1:0]  d_st, w_st, s_st;

    ber_monitor #(.FIFO_DEPTH(64), .WINDOW(1024), .CNT_W(16)) u_def (
        .clk_sig(clk_sig), .reset_sig(reset_sig), .clear(clear), .bus(if_def.slave),
        .err_count(d_err), .bit_count(d_bit), .window_done(d_wd), .total_err(d_tot),
        .fifo_level(d_lvl), .state(d_st), .fault(d_flt));

    ber_monitor #(.FIFO_DEPTH(64), .WINDOW(8), .CNT_W(16)) u_win (
        .clk_sig(clk_sig), .reset_sig(reset_sig), .clear(clear), .bus(if_win.slave),
        .err_count(w_err), .bit_count(w_bit), .window_done(w_wd), .total_err(w_tot),
        .fifo_level(w_lvl), .state(w_st), .fault(w_flt));

    ber_monitor #(.FIFO_DEPTH(4), .WINDOW(1024), .CNT_W(16)) u_sml (
        .clk_sig(clk_sig), .reset_sig(reset_sig), .clear(clear), .bus(if_sml.slave),
        .err_count(s_err), .bit_count(s_bit), .window_done(s_wd), .total_err(s_tot),
        .fifo_level(s_lvl), .state(s_st), .fault(s_flt));

    int n_checks = 0;
    int n_fail   = 0;
    bit src_q[$];
    int exp_q[$];

    task automatic tick();
        @(posedge clk_sig);
        #1;
    endtask

    task automatic idle_all();
        if_def.src_bit = 1'b0; if_def.src_valid = 1'b0; if_def.dec_bit = 1'b0; if_def.dec_valid = 1'b0;
        if_win.src_bit = 1'b0; if_win.src_valid = 1'b0; if_win.dec_bit = 1'b0; if_win.dec_valid = 1'b0;
        if_sml.src_bit = 1'b0; if_sml.src_valid = 1'b0; if_sml.dec_bit = 1'b0; if_sml.dec_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        clear = 1'b0;
        reset_sig = 1'b0;
        tick();
        reset_sig = 1'b1;
        src_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle_all();
        clear = 1'b0;
        reset_sig = 1'b0;
        tick();
        tick();
        reset_sig = 1'b1;
        tick();
        n_checks++; if (d_err !== 16'd0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", d_err); end
        n_checks++; if (d_bit !== 16'd0) begin n_fail++; $display("FAIL reset_bit got %0d exp 0", d_bit); end
        n_checks++; if (d_wd !== 1'b0) begin n_fail++; $display("FAIL reset_wd got %0b exp 0", d_wd); end
        n_checks++; if (d_tot !== 32'd0) begin n_fail++; $display("FAIL reset_tot got %0d exp 0", d_tot); end
        n_checks++; if (d_lvl !== 7'd0) begin n_fail++; $display("FAIL reset_lvl got %0d exp 0", d_lvl); end
        n_checks++; if (d_st !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", d_st); end
        n_checks++; if (d_flt !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b exp 0", d_flt); end
        n_checks++; if (s_lvl !== 3'd0) begin n_fail++; $display("FAIL reset_sml_lvl got %0d exp 0", s_lvl); end
    endtask

    task automatic test_basic();
        bit b;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b = 1'($urandom_range(0, 1));
            if_def.src_bit = b; if_def.src_valid = 1'b1;
            src_q.push_back(b);
            tick();
        end
        if_def.src_valid = 1'b0;
        n_checks++; if (d_lvl !== 7'd10) begin n_fail++; $display("FAIL basic_fill_lvl got %0d exp 10", d_lvl); end
        n_checks++; if (d_st !== 2'd0) begin n_fail++; $display("FAIL basic_idle got %0d exp 0", d_st); end
        for (int i = 0; i < 10; i++) begin
            if_def.dec_valid = 1'b1;
            if_def.dec_bit = src_q.pop_front();
            tick();
            if (i == 0) begin
                n_checks++; if (d_st !== 2'd1) begin n_fail++; $display("FAIL basic_run got %0d exp 1", d_st); end
            end
        end
        if_def.dec_valid = 1'b0;
        tick();
        n_checks++; if (d_lvl !== 7'd0) begin n_fail++; $display("FAIL basic_drain_lvl got %0d exp 0", d_lvl); end
        n_checks++; if (d_bit !== 16'd10) begin n_fail++; $display("FAIL basic_bit got %0d exp 10", d_bit); end
        n_checks++; if (d_tot !== 32'd0) begin n_fail++; $display("FAIL basic_tot got %0d exp 0", d_tot); end
        n_checks++; if (d_flt !== 1'b0) begin n_fail++; $display("FAIL basic_fault got %0b exp 0", d_flt); end
    endtask

    task automatic test_window();
        bit hist [16];
        int k, e, ncmp, run_err, exp_total, pulses;
        do_reset();
        ncmp = 0; run_err = 0; exp_total = 0; pulses = 0;
        for (int c = 0; c < 26; c++) begin
            if (c < 16) begin
                hist[c] = 1'($urandom_range(0, 1));
                if_win.src_bit = hist[c]; if_win.src_valid = 1'b1;
            end else begin
                if_win.src_valid = 1'b0;
            end
            if (c >= 5 && c < 21) begin
                k = c - 5;
                if_win.dec_bit = hist[k] ^ ((k % 3) == 1);
                if_win.dec_valid = 1'b1;
                if ((k % 3) == 1) begin run_err++; exp_total++; end
                ncmp++;
                if ((ncmp % 8) == 0) begin exp_q.push_back(run_err); run_err = 0; end
            end else begin
                if_win.dec_valid = 1'b0;
            end
            tick();
            if (w_wd === 1'b1) begin
                pulses++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL window_extra_pulse got pulse %0d exp none", pulses);
                end else begin
                    e = exp_q.pop_front();
                    if (w_err !== 16'(e)) begin n_fail++; $display("FAIL window_err got %0d exp %0d", w_err, e); end
                end
            end
        end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL window_pulses got %0d exp 2", pulses); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL window_missing got %0d left exp 0", exp_q.size()); end
        n_checks++; if (w_tot !== 32'(exp_total)) begin n_fail++; $display("FAIL window_tot got %0d exp %0d", w_tot, exp_total); end
        n_checks++; if (w_bit !== 16'd0) begin n_fail++; $display("FAIL window_bit got %0d exp 0", w_bit); end
    endtask

    task automatic test_overflow();
        bit ov_bits [4];
        int wd_seen;
        do_reset();
        wd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin ov_bits[i] = 1'($urandom_range(0, 1)); if_sml.src_bit = ov_bits[i]; end
            if_sml.src_valid = 1'b1;
            tick();
            if (i == 3) begin
                n_checks++; if (s_flt !== 1'b0) begin n_fail++; $display("FAIL ovf_early_fault got %0b exp 0", s_flt); end
            end
        end
        if_sml.src_valid = 1'b0;
        n_checks++; if (s_flt !== 1'b1) begin n_fail++; $display("FAIL ovf_fault got %0b exp 1", s_flt); end
        n_checks++; if (s_st !== 2'd2) begin n_fail++; $display("FAIL ovf_state got %0d exp 2", s_st); end
        n_checks++; if (s_lvl !== 3'd4) begin n_fail++; $display("FAIL ovf_lvl got %0d exp 4", s_lvl); end
        for (int i = 0; i < 4; i++) begin
            if_sml.dec_valid = 1'b1; if_sml.dec_bit = ~ov_bits[i];
            tick();
            if (s_wd === 1'b1) wd_seen++;
        end
        if_sml.dec_valid = 1'b0;
        tick(); tick();
        n_checks++; if (s_tot !== 32'd0) begin n_fail++; $display("FAIL ovf_frozen_tot got %0d exp 0", s_tot); end
        n_checks++; if (s_bit !== 16'd0) begin n_fail++; $display("FAIL ovf_frozen_bit got %0d exp 0", s_bit); end
        n_checks++; if (wd_seen != 0) begin n_fail++; $display("FAIL ovf_wd got %0d exp 0", wd_seen); end
    endtask

    task automatic test_underflow();
        bit b;
        do_reset();
        b = 1'($urandom_range(0, 1));
        if_sml.src_bit = b; if_sml.src_valid = 1'b1;
        tick();
        if_sml.src_valid = 1'b0;
        if_sml.dec_valid = 1'b1; if_sml.dec_bit = ~b;
        tick();
        n_checks++; if (s_st !== 2'd1) begin n_fail++; $display("FAIL udf_run got %0d exp 1", s_st); end
        tick();
        if_sml.dec_valid = 1'b0;
        n_checks++; if (s_st !== 2'd2) begin n_fail++; $display("FAIL udf_state got %0d exp 2", s_st); end
        n_checks++; if (s_flt !== 1'b1) begin n_fail++; $display("FAIL udf_fault got %0b exp 1", s_flt); end
        n_checks++; if (s_bit !== 16'd1) begin n_fail++; $display("FAIL udf_bit got %0d exp 1", s_bit); end
        n_checks++; if (s_tot !== 32'd1) begin n_fail++; $display("FAIL udf_tot got %0d exp 1", s_tot); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (s_st !== 2'd0) begin n_fail++; $display("FAIL clr_state got %0d exp 0", s_st); end
        n_checks++; if (s_flt !== 1'b0) begin n_fail++; $display("FAIL clr_fault got %0b exp 0", s_flt); end
        n_checks++; if (s_bit !== 16'd0) begin n_fail++; $display("FAIL clr_bit got %0d exp 0", s_bit); end
        n_checks++; if (s_tot !== 32'd0) begin n_fail++; $display("FAIL clr_tot got %0d exp 0", s_tot); end
        n_checks++; if (s_err !== 16'd0) begin n_fail++; $display("FAIL clr_err got %0d exp 0", s_err); end
    endtask

    task automatic test_back_to_back();
        bit b, nb, flip;
        int exp_total;
        do_reset();
        exp_total = 0;
        for (int i = 0; i < 4; i++) begin
            b = 1'($urandom_range(0, 1));
            if_sml.src_bit = b; if_sml.src_valid = 1'b1; src_q.push_back(b);
            tick();
        end
        n_checks++; if (s_lvl !== 3'd4) begin n_fail++; $display("FAIL b2b_full got %0d exp 4", s_lvl); end
        for (int i = 0; i < 20; i++) begin
            nb = 1'($urandom_range(0, 1));
            flip = ((i % 7) == 3);
            if (flip) exp_total++;
            b = src_q.pop_front();
            src_q.push_back(nb);
            if_sml.src_bit = nb; if_sml.src_valid = 1'b1;
            if_sml.dec_bit = b ^ flip; if_sml.dec_valid = 1'b1;
            tick();
            n_checks++; if (s_lvl !== 3'd4) begin n_fail++; $display("FAIL b2b_lvl cycle %0d got %0d exp 4", i, s_lvl); end
        end
        if_sml.src_valid = 1'b0; if_sml.dec_valid = 1'b0;
        tick();
        n_checks++; if (s_bit !== 16'd20) begin n_fail++; $display("FAIL b2b_bit got %0d exp 20", s_bit); end
        n_checks++; if (s_tot !== 32'(exp_total)) begin n_fail++; $display("FAIL b2b_tot got %0d exp %0d", s_tot, exp_total); end
        n_checks++; if (s_flt !== 1'b0) begin n_fail++; $display("FAIL b2b_fault got %0b exp 0", s_flt); end
        n_checks++; if (s_st !== 2'd1) begin n_fail++; $display("FAIL b2b_state got %0d exp 1", s_st); end
    endtask

    task automatic test_reset_mid_window();
        bit b, flip;
        int run_err, first_err;
        do_reset();
        run_err = 0; first_err = 0;
        for (int i = 0; i < 13; i++) begin
            b = 1'($urandom_range(0, 1));
            if_win.src_bit = b; if_win.src_valid = 1'b1; src_q.push_back(b);
            tick();
        end
        if_win.src_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            flip = ((i % 4) == 0);
            if (flip) run_err++;
            if (i == 7) begin first_err = run_err; run_err = 0; end
            if_win.dec_bit = src_q.pop_front() ^ flip; if_win.dec_valid = 1'b1;
            tick();
        end
        if_win.dec_valid = 1'b0;
        tick();
        n_checks++; if (w_bit !== 16'd5) begin n_fail++; $display("FAIL mid_bit got %0d exp 5", w_bit); end
        n_checks++; if (w_err !== 16'(first_err)) begin n_fail++; $display("FAIL mid_err got %0d exp %0d", w_err, first_err); end
        reset_sig = 1'b0;
        tick();
        n_checks++; if (w_bit !== 16'd0) begin n_fail++; $display("FAIL rst_mid_bit got %0d exp 0", w_bit); end
        n_checks++; if (w_err !== 16'd0) begin n_fail++; $display("FAIL rst_mid_err got %0d exp 0", w_err); end
        n_checks++; if (w_st !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d exp 0", w_st); end
        n_checks++; if (w_wd !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wd got %0b exp 0", w_wd); end
        reset_sig = 1'b1;
        tick();
        n_checks++; if (w_wd !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wd_after got %0b exp 0", w_wd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_sig = 1'b0;
        clear = 1'b0;
        idle_all();
        test_reset();
        test_basic();
        test_window();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
